// File: rtl/fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmp_arbiter
// Purpose  : Round-robin front end that shares one pipelined less_than
//            comparator among N requesters. It grants one requester per
//            cycle, registers the granted operand pair onto the comparator
//            inputs, and carries a tag (valid + requester index) alongside
//            the comparator pipeline so that each result is routed back to
//            the requester that issued it. There is no stall and no response
//            backpressure.
// Ports    :
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [N]          requester has an operand pair pending
//   req_a      in   [N*(W+1)]    operand A per requester (slice i)
//   req_b      in   [N*(W+1)]    operand B per requester (slice i)
//   req_ready  out  [N]          one-hot grant
//   hold       in   blocks new grants, in-flight work still completes
//   cmp_a      out  [W+1]        registered operand A to comparator
//   cmp_b      out  [W+1]        registered operand B to comparator
//   cmp_less   in   comparator result, LAT cycles after cmp_a/cmp_b
//   rsp_valid  out  [N]          one-cycle response pulse to requester
//   rsp_less   out  comparison result (0 when no response)
//   inflight   out  issued-but-not-responded operation count
// Revision : 1.0  initial release
// ============================================================================
module fp_cmp_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 23,
    parameter int LAT   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    input  logic [N*(WIDTH+1)-1:0]   req_a,
    input  logic [N*(WIDTH+1)-1:0]   req_b,
    output logic [N-1:0]             req_ready,
    input  logic                     hold,
    output logic [WIDTH:0]           cmp_a,
    output logic [WIDTH:0]           cmp_b,
    input  logic                     cmp_less,
    output logic [N-1:0]             rsp_valid,
    output logic                     rsp_less,
    output logic [$clog2(LAT+2)-1:0] inflight
);

    localparam int OW = WIDTH + 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(LAT + 2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] r_ptr;
    logic [OW-1:0] r_cmp_a;
    logic [OW-1:0] r_cmp_b;
    logic [LAT:0]  r_tag_v;
    logic [PW-1:0] r_tag_i [0:LAT];
    logic [IW-1:0] r_inflight;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or above the pointer,
    // wrapping modulo N. Reset and hold both suppress any grant.
    // ------------------------------------------------------------------
    logic [N-1:0]  w_grant;
    logic [PW-1:0] w_gidx;
    logic          w_found;
    int            w_cand;

    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_cand  = 0;
        if (!rst && !hold) begin
            for (int k = 0; k < N; k++) begin
                w_cand = int'(r_ptr) + k;
                if (w_cand >= N) begin
                    w_cand = w_cand - N;
                end
                if (!w_found && req_valid[w_cand]) begin
                    w_found = 1'b1;
                    w_gidx  = PW'(w_cand);
                end
            end
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // A grant is only ever issued to a valid requester, so grant == transfer.
    logic w_xfer;
    logic w_rsp;
    assign w_xfer = w_found;
    assign w_rsp  = r_tag_v[LAT];

    // ------------------------------------------------------------------
    // Sequential: pointer, operand registers, tag pipeline, occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cmp_a    <= '0;
            r_cmp_b    <= '0;
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_tag_i[k] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr   <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
                r_cmp_a <= req_a[w_gidx*OW +: OW];
                r_cmp_b <= req_b[w_gidx*OW +: OW];
            end
            // Tag stage k lines up with the comparator's internal stage k;
            // stage LAT coincides with a valid cmp_less.
            r_tag_v[0] <= w_xfer;
            r_tag_i[0] <= w_gidx;
            for (int k = 1; k <= LAT; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag_i[k] <= r_tag_i[k-1];
            end
            r_inflight <= r_inflight + IW'(w_xfer) - IW'(w_rsp);
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        if (w_rsp) begin
            rsp_valid[r_tag_i[LAT]] = 1'b1;
        end
    end

    assign rsp_less  = w_rsp & cmp_less;
    assign req_ready = w_grant;
    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_cmp_arbiter
// Purpose  : Directed self-checking bench for fp_cmp_arbiter, including a
//            behavioural LAT-stage less_than comparator reset by rst.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_cmp_arbiter;

    localparam int N   = 4;
    localparam int W   = 23;
    localparam int LAT = 3;
    localparam int OW  = W + 1;
    localparam int IW  = $clog2(LAT + 2);

    localparam logic [OW-1:0] c_ONE = 24'h4FFC00;
    localparam logic [OW-1:0] c_TWO = 24'h500000;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*OW-1:0]   req_a;
    logic [N*OW-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic [OW-1:0]     cmp_a;
    logic [OW-1:0]     cmp_b;
    logic              cmp_less;
    logic [N-1:0]      rsp_valid;
    logic              rsp_less;
    logic [IW-1:0]     inflight;

    int passed = 0;
    int total  = 0;

    fp_cmp_arbiter #(.N(N), .WIDTH(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_less  (cmp_less),
        .rsp_valid (rsp_valid),
        .rsp_less  (rsp_less),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference less_than: exn 00 is zero, otherwise sign/magnitude order.
    function automatic logic fp_less(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [20:0] ma, mb;
        logic        sa, sb;
        ma = (a[23:22] == 2'b00) ? 21'd0 : a[20:0];
        mb = (b[23:22] == 2'b00) ? 21'd0 : b[20:0];
        sa = a[21] && (ma != 0);
        sb = b[21] && (mb != 0);
        if (sa != sb) return sa;
        if (!sa)      return ma < mb;
        return ma > mb;
    endfunction

    logic [LAT-1:0] m_pipe;
    always @(posedge clk) begin
        if (rst) m_pipe <= '0;
        else     m_pipe <= {m_pipe[LAT-2:0], fp_less(cmp_a, cmp_b)};
    end
    assign cmp_less = m_pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_ops(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b);
        req_a[i*OW +: OW] = a;
        req_b[i*OW +: OW] = b;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = 4'b1111;
        req_a = '0; req_b = '0;
        tick(); tick();
        // Reset state
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_inflight", 32'(inflight),  32'h0);
        chk("rst_cmp_a",    32'(cmp_a),     32'h0);
        chk("rst_cmp_b",    32'(cmp_b),     32'h0);
        chk("rst_rsp",      32'(rsp_valid), 32'h0);
        rst = 1'b0; req_valid = 4'b0000;
        #1;

        // Single request: 1.0 < 2.0
        set_ops(0, c_ONE, c_TWO);
        req_valid = 4'b0001; #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000; #1;
        chk("single_ready_off", 32'(req_ready), 32'h0);
        chk("single_cmp_a",     32'(cmp_a),     32'(c_ONE));
        chk("single_cmp_b",     32'(cmp_b),     32'(c_TWO));
        chk("single_inflight",  32'(inflight),  32'h1);
        tick(); chk("single_rsp_e1", 32'(rsp_valid), 32'h0);
        tick(); chk("single_rsp_e2", 32'(rsp_valid), 32'h0);
        tick();
        chk("single_rsp",      32'(rsp_valid), 32'h1);
        chk("single_less",     32'(rsp_less),  32'h1);
        tick();
        chk("single_rsp_done", 32'(rsp_valid), 32'h0);
        chk("single_less_0",   32'(rsp_less),  32'h0);
        chk("single_drain",    32'(inflight),  32'h0);

        // Equal and greater, back to back from requesters 1 and 2
        set_ops(1, c_ONE, c_ONE);
        set_ops(2, c_TWO, c_ONE);
        req_valid = 4'b0110; #1;
        chk("eq_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100; #1;
        chk("eq_ready2", 32'(req_ready), 32'h4);
        chk("eq_cmp_a",  32'(cmp_a),     32'(c_ONE));
        tick();
        req_valid = 4'b0000; #1;
        chk("gt_cmp_a",     32'(cmp_a),    32'(c_TWO));
        chk("eq_inflight2", 32'(inflight), 32'h2);
        tick(); chk("eq_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("eq_rsp",  32'(rsp_valid), 32'h2);
        chk("eq_less", 32'(rsp_less),  32'h0);
        tick();
        chk("gt_rsp",  32'(rsp_valid), 32'h4);
        chk("gt_less", 32'(rsp_less),  32'h0);
        tick();
        chk("eqgt_drain", 32'(inflight), 32'h0);

        // Pointer wrap: pointer now at 3; requesters 0 and 3 alternate
        req_valid = 4'b1001; #1;
        chk("wrap_g3", 32'(req_ready), 32'h8);
        tick();
        chk("wrap_g0", 32'(req_ready), 32'h1);
        tick();
        chk("wrap_g3b", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000; #1;
        tick();
        chk("wrap_rsp3",  32'(rsp_valid), 32'h8);
        chk("wrap_less3", 32'(rsp_less),  32'h0);
        tick();
        chk("wrap_rsp0",  32'(rsp_valid), 32'h1);
        chk("wrap_less0", 32'(rsp_less),  32'h1);
        tick();
        chk("wrap_rsp3b", 32'(rsp_valid), 32'h8);
        tick();
        chk("wrap_drain", 32'(inflight), 32'h0);

        // Contention: all four held for 8 grants, pointer starts at 0
        req_valid = 4'b1111; #1;
        for (int k = 0; k <= 12; k++) begin
            if (k == 8) begin
                req_valid = 4'b0000; #1;
            end
            if (k < 8) chk("cont_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 4 && k <= 11) begin
                chk("cont_rsp",  32'(rsp_valid), 32'(1 << ((k - 4) % 4)));
                chk("cont_less", 32'(rsp_less),  32'(((k - 4) % 4) == 0));
            end else begin
                chk("cont_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            chk("cont_inflight", 32'(inflight), 32'((k <= 8) ? ((k < 4) ? k : 4) : 12 - k));
            if (k < 12) tick();
        end

        // Hold with two operations in flight
        req_valid = 4'b1111; #1;
        tick(); tick();
        hold = 1'b1; #1;
        chk("hold_ready",    32'(req_ready), 32'h0);
        chk("hold_inflight", 32'(inflight),  32'h2);
        tick();
        chk("hold_ready2", 32'(req_ready), 32'h0);
        chk("hold_rsp_e",  32'(rsp_valid), 32'h0);
        tick();
        chk("hold_rsp0",  32'(rsp_valid), 32'h1);
        chk("hold_less0", 32'(rsp_less),  32'h1);
        tick();
        chk("hold_rsp1",  32'(rsp_valid), 32'h2);
        tick();
        chk("hold_drain", 32'(inflight),  32'h0);
        chk("hold_rsp_z", 32'(rsp_valid), 32'h0);
        hold = 1'b0; req_valid = 4'b0000; #1;

        // Reset after three issues (pointer at 2: grants 2,3,0)
        req_valid = 4'b1111; #1;
        tick(); tick(); tick();
        rst = 1'b1; #1;
        chk("mrst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0; req_valid = 4'b0000; #1;
        chk("mrst_inflight", 32'(inflight), 32'h0);
        chk("mrst_cmp_a",    32'(cmp_a),    32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("mrst_no_rsp", 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 4'b1111; #1;
        chk("mrst_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000; #1;
        chk("mrst_inflight1", 32'(inflight), 32'h1);
        tick(); tick(); tick();
        chk("mrst_rsp0", 32'(rsp_valid), 32'h1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
